// File: rtl/voice_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_pkg;

  localparam int NOTE_W         = 7;
  localparam int VEL_W          = 7;
  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_AGE_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    APPLY  = 2'd2
  } state_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } cmd_t;

endpackage

// File: rtl/voice_alloc_select.sv
// Combinational voice search: matching note, first free voice, oldest voice.
module voice_alloc_select
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W,
  localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic [NUM_VOICES-1:0]        gate,
  input  logic [NOTE_W*NUM_VOICES-1:0] note,
  input  logic [AGE_W*NUM_VOICES-1:0]  age,
  input  logic [NOTE_W-1:0]            key,
  output logic [NUM_VOICES-1:0]        match_mask,
  output logic                         match_found,
  output logic [IDX_W-1:0]             match_idx,
  output logic                         free_found,
  output logic [IDX_W-1:0]             free_idx,
  output logic [IDX_W-1:0]             oldest_idx,
  output logic                         steal
);

  logic [AGE_W-1:0] best_age;

  // Descending scan so the lowest index wins; oldest uses strict '>' for the same reason.
  always_comb begin
    match_mask  = '0;
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    oldest_idx  = '0;
    best_age    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      match_mask[i] = gate[i] && (note[i*NOTE_W +: NOTE_W] == key);
      if (match_mask[i]) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!gate[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (age[i*AGE_W +: AGE_W] > best_age) begin
        best_age   = age[i*AGE_W +: AGE_W];
        oldest_idx = IDX_W'(i);
      end
    end
    steal = !match_found && !free_found;
  end

endmodule

// File: rtl/voice_allocator.sv
// Note-on/off voice allocator with retrigger, free-voice search and oldest-voice stealing.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W,
  localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int CNT_W     = $clog2(NUM_VOICES + 1)
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_on,
  input  logic [NOTE_W-1:0]            cmd_note,
  input  logic [VEL_W-1:0]             cmd_vel,
  input  logic                         all_notes_off,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic                         steal_pulse,
  output logic [CNT_W-1:0]             active_count
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t                        state;
  logic                          ready_en;
  cmd_t                          cmd_q;
  logic                          sel_on;
  logic                          sel_steal;
  logic [IDX_W-1:0]              sel_idx;
  logic [NUM_VOICES-1:0]         off_mask;
  logic [AGE_W*NUM_VOICES-1:0]   age_q;

  logic [NUM_VOICES-1:0]         match_mask;
  logic                          match_found;
  logic [IDX_W-1:0]              match_idx;
  logic                          free_found;
  logic [IDX_W-1:0]              free_idx;
  logic [IDX_W-1:0]              oldest_idx;
  logic                          steal;

  logic [NUM_VOICES-1:0]         gate_nxt;
  logic [NUM_VOICES-1:0]         trig_nxt;
  logic [AGE_W*NUM_VOICES-1:0]   age_nxt;
  logic [NOTE_W*NUM_VOICES-1:0]  note_nxt;
  logic [VEL_W*NUM_VOICES-1:0]   vel_nxt;

  // ready_en keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = ready_en && (state == IDLE) && !all_notes_off;

  voice_alloc_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_select (
    .gate        (voice_gate),
    .note        (voice_note),
    .age         (age_q),
    .key         (cmd_q.note),
    .match_mask  (match_mask),
    .match_found (match_found),
    .match_idx   (match_idx),
    .free_found  (free_found),
    .free_idx    (free_idx),
    .oldest_idx  (oldest_idx),
    .steal       (steal)
  );

  always_comb begin
    gate_nxt = voice_gate;
    trig_nxt = '0;
    age_nxt  = age_q;
    note_nxt = voice_note;
    vel_nxt  = voice_vel;
    if (sel_on) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == sel_idx) begin
          gate_nxt[i]                  = 1'b1;
          trig_nxt[i]                  = 1'b1;
          age_nxt[i*AGE_W +: AGE_W]    = '0;
          note_nxt[i*NOTE_W +: NOTE_W] = cmd_q.note;
          vel_nxt[i*VEL_W +: VEL_W]    = cmd_q.vel;
        end else if (voice_gate[i] && (age_q[i*AGE_W +: AGE_W] != AGE_MAX)) begin
          age_nxt[i*AGE_W +: AGE_W] = age_q[i*AGE_W +: AGE_W] + AGE_W'(1);
        end
      end
    end else begin
      gate_nxt = voice_gate & ~off_mask;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      cmd_q        <= '0;
      sel_on       <= 1'b0;
      sel_steal    <= 1'b0;
      sel_idx      <= '0;
      off_mask     <= '0;
      age_q        <= '0;
      voice_gate   <= '0;
      voice_trig   <= '0;
      voice_note   <= '0;
      voice_vel    <= '0;
      steal_pulse  <= 1'b0;
      active_count <= '0;
    end else begin
      ready_en    <= 1'b1;
      voice_trig  <= '0;
      steal_pulse <= 1'b0;
      if (all_notes_off) begin
        state        <= IDLE;
        voice_gate   <= '0;
        age_q        <= '0;
        active_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              cmd_q <= '{on: cmd_on, note: cmd_note, vel: cmd_vel};
              state <= LOOKUP;
            end
          end
          LOOKUP: begin
            // A zero-velocity note-on behaves exactly like a note-off.
            sel_on    <= cmd_q.on && (cmd_q.vel != '0);
            sel_steal <= cmd_q.on && (cmd_q.vel != '0) && steal;
            sel_idx   <= match_found ? match_idx : (free_found ? free_idx : oldest_idx);
            off_mask  <= match_mask;
            state     <= APPLY;
          end
          APPLY: begin
            voice_gate   <= gate_nxt;
            voice_trig   <= trig_nxt;
            age_q        <= age_nxt;
            voice_note   <= note_nxt;
            voice_vel    <= vel_nxt;
            steal_pulse  <= sel_steal;
            active_count <= CNT_W'($countones(gate_nxt));
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: vector table with scoreboard plus panic/reset corner sequences.
module tb_voice_allocator;
  import voice_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_on;
  logic [6:0]        cmd_note;
  logic [6:0]        cmd_vel;
  logic              all_notes_off;
  logic [N-1:0]      voice_gate;
  logic [N-1:0]      voice_trig;
  logic [7*N-1:0]    voice_note;
  logic [7*N-1:0]    voice_vel;
  logic              steal_pulse;
  logic [CW-1:0]     active_count;

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    int         idx;
    logic       steal;
    int         count;
  } vec_t;

  typedef struct {
    logic [N-1:0]   gate;
    logic [7*N-1:0] note;
    logic [7*N-1:0] vel;
    logic [N-1:0]   trig;
    logic           steal;
    logic [CW-1:0]  count;
  } exp_t;

  exp_t       sb[$];
  vec_t       tbl[$];
  logic [N-1:0] m_gate;
  logic [6:0] m_note[N];
  logic [6:0] m_vel[N];
  int         checks;
  int         failures;

  voice_allocator #(.NUM_VOICES(N), .AGE_W(8)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_on        (cmd_on),
    .cmd_note      (cmd_note),
    .cmd_vel       (cmd_vel),
    .all_notes_off (all_notes_off),
    .voice_gate    (voice_gate),
    .voice_trig    (voice_trig),
    .voice_note    (voice_note),
    .voice_vel     (voice_vel),
    .steal_pulse   (steal_pulse),
    .active_count  (active_count)
  );

  always #5 ACLK = ~ACLK;

  function automatic vec_t mk(input int on, input int note, input int vel,
                              input int idx, input int steal, input int count);
    vec_t v;
    v.on    = (on != 0);
    v.note  = 7'(note);
    v.vel   = 7'(vel);
    v.idx   = idx;
    v.steal = (steal != 0);
    v.count = count;
    return v;
  endfunction

  task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic modelClear(input logic clear_data);
    m_gate = '0;
    if (clear_data) begin
      for (int j = 0; j < N; j++) begin
        m_note[j] = '0;
        m_vel[j]  = '0;
      end
    end
  endtask

  // Drives one command (waiting for ready), updates the model and queues the expected outputs.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge ACLK);
      waited++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout actual=0 required=1");
    end
    cmd_valid = 1'b1;
    cmd_on    = v.on;
    cmd_note  = v.note;
    cmd_vel   = v.vel;
    e.trig  = '0;
    e.steal = v.steal;
    e.count = CW'(v.count);
    if (v.on && v.vel != 0) begin
      m_gate[v.idx] = 1'b1;
      m_note[v.idx] = v.note;
      m_vel[v.idx]  = v.vel;
      e.trig[v.idx] = 1'b1;
    end else begin
      for (int j = 0; j < N; j++)
        if (m_gate[j] && m_note[j] == v.note) m_gate[j] = 1'b0;
    end
    e.gate = m_gate;
    for (int j = 0; j < N; j++) begin
      e.note[j*7 +: 7] = m_note[j];
      e.vel[j*7 +: 7]  = m_vel[j];
    end
    sb.push_back(e);
    @(posedge ACLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    expectEq("gate",  64'(voice_gate),   64'(e.gate));
    expectEq("note",  64'(voice_note),   64'(e.note));
    expectEq("vel",   64'(voice_vel),    64'(e.vel));
    expectEq("trig",  64'(voice_trig),   64'(e.trig));
    expectEq("steal", 64'(steal_pulse),  64'(e.steal));
    expectEq("count", 64'(active_count), 64'(e.count));
  endtask

  // One full command: busy during LOOKUP/APPLY, results two edges after transfer, pulses last one cycle.
  task automatic runVector(input vec_t v);
    applyStimulus(v);
    @(negedge ACLK);
    expectEq("ready_lookup", 64'(cmd_ready), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    expectEq("ready_apply", 64'(cmd_ready), 64'd0);
    expectEq("trig_early",  64'(voice_trig), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    checkOutput();
    expectEq("ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    expectEq("trig_clear",  64'(voice_trig), 64'd0);
    expectEq("steal_clear", 64'(steal_pulse), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    ARESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_on = 1'b0;
    cmd_note = '0;
    cmd_vel = '0;
    all_notes_off = 1'b0;
    modelClear(1'b1);

    // on, note, vel, expected voice, expected steal, expected active_count
    tbl.push_back(mk(1, 60, 100, 0, 0, 1));
    tbl.push_back(mk(1, 60,  50, 0, 0, 1));
    tbl.push_back(mk(0, 60,  64, -1, 0, 0));
    tbl.push_back(mk(0, 61,  64, -1, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 60 + k, 100, k, 0, k + 1));
    tbl.push_back(mk(1, 68, 101, 0, 1, 8));
    tbl.push_back(mk(1, 69, 102, 1, 1, 8));
    tbl.push_back(mk(1, 65,   0, -1, 0, 7));
    tbl.push_back(mk(1, 70, 103, 5, 0, 8));
    tbl.push_back(mk(1, 64,  20, 4, 0, 8));

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    expectEq("rst_ready", 64'(cmd_ready), 64'd0);
    expectEq("rst_gate",  64'(voice_gate), 64'd0);
    expectEq("rst_note",  64'(voice_note), 64'd0);
    expectEq("rst_vel",   64'(voice_vel), 64'd0);
    expectEq("rst_trig",  64'(voice_trig), 64'd0);
    expectEq("rst_steal", 64'(steal_pulse), 64'd0);
    expectEq("rst_count", 64'(active_count), 64'd0);
    ARESET = 1'b0;
    #1 expectEq("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    expectEq("ready_after_rst", 64'(cmd_ready), 64'd1);

    for (int k = 0; k < tbl.size(); k++) runVector(tbl[k]);

    // Panic from IDLE clears every gate, leaves note/vel untouched.
    all_notes_off = 1'b1;
    #1 expectEq("ready_in_panic", 64'(cmd_ready), 64'd0);
    @(posedge ACLK);
    #1 all_notes_off = 1'b0;
    modelClear(1'b0);
    @(negedge ACLK);
    expectEq("panic_gate",  64'(voice_gate), 64'd0);
    expectEq("panic_count", 64'(active_count), 64'd0);

    for (int k = 0; k < 4; k++) runVector(mk(1, 40 + k, 90, k, 0, k + 1));

    // Panic while a command sits in LOOKUP: command dropped, ready one cycle later.
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    cmd_note  = 7'd50;
    cmd_vel   = 7'd9;
    @(posedge ACLK);
    #1 cmd_valid = 1'b0;
    all_notes_off = 1'b1;
    @(posedge ACLK);
    #1 all_notes_off = 1'b0;
    modelClear(1'b0);
    @(negedge ACLK);
    expectEq("lookup_panic_gate",  64'(voice_gate), 64'd0);
    expectEq("lookup_panic_count", 64'(active_count), 64'd0);
    expectEq("lookup_panic_trig",  64'(voice_trig), 64'd0);
    expectEq("lookup_panic_steal", 64'(steal_pulse), 64'd0);
    expectEq("lookup_panic_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    expectEq("dropped_gate", 64'(voice_gate), 64'd0);
    expectEq("dropped_trig", 64'(voice_trig), 64'd0);

    // Reset asserted during APPLY clears everything immediately and discards the command.
    runVector(mk(1, 30, 77, 0, 0, 1));
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    cmd_note  = 7'd31;
    cmd_vel   = 7'd66;
    @(posedge ACLK);
    #1 cmd_valid = 1'b0;
    @(posedge ACLK);
    #1 ARESET = 1'b1;
    #1;
    expectEq("async_gate",  64'(voice_gate), 64'd0);
    expectEq("async_note",  64'(voice_note), 64'd0);
    expectEq("async_vel",   64'(voice_vel), 64'd0);
    expectEq("async_count", 64'(active_count), 64'd0);
    expectEq("async_ready", 64'(cmd_ready), 64'd0);
    modelClear(1'b1);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1 expectEq("async_ready_pre", 64'(cmd_ready), 64'd0);
    @(posedge ACLK);
    #1;
    expectEq("async_ready_post", 64'(cmd_ready), 64'd1);
    expectEq("async_discard",    64'(voice_gate), 64'd0);
    @(negedge ACLK);
    runVector(mk(1, 33, 44, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
